uart_tx_scheduler: RTL and testbench

- Bus master that configures the 16550-style UART bus slave after reset, then shares its transmitter between NR_REQ byte-stream requesters.
- Programs divisor/line/FIFO control with single-beat bus writes, then loops:
  - poll the line-status register (LSR);
  - when the TX FIFO is empty, push up to TX_BURST bytes, chosen round-robin among pending requesters.
- Sits between on-chip byte producers (debug/log sources) and the system bus arbiter.

---
 rtl/uart_sched_pkg.sv | 47 ++++
 rtl/uart_sched_rr_arbiter.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_sched_pkg;

  // Master FSM: ST_INIT is also the op-select state between transactions.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEGIN = 3'd2,
    ST_WDATA = 3'd3,
    ST_WEND  = 3'd4,
    ST_RWAIT = 3'd5,
    ST_REND  = 3'd6
  } state_t;

  // 16550 register offsets (DLL/DLM alias RBR_THR/IER while LCR.DLAB=1).
  localparam logic [2:0] RBR_THR = 3'd0;
  localparam logic [2:0] IER_DLM = 3'd1;
  localparam logic [2:0] FCR     = 3'd2;
  localparam logic [2:0] LCR     = 3'd3;
  localparam logic [2:0] LSR     = 3'd5;

  localparam int         LSR_THRE_BIT = 5;
  localparam logic [7:0] FCR_INIT     = 8'h07;
  localparam logic [2:0] INIT_OPS     = 3'd5;

  typedef struct packed {
    logic [2:0] off;
    logic [7:0] dat;
  } init_op_t;

  // Configuration write number idx: open divisor latch, load it, close latch, enable FIFOs.
  function automatic init_op_t init_op(input logic [2:0] idx, input logic [7:0] lcr,
                                       input logic [15:0] div);
    init_op_t op;
    case (idx)
      3'd0:    op = '{off: LCR,     dat: 8'h80 | lcr};
      3'd1:    op = '{off: RBR_THR, dat: div[7:0]};
      3'd2:    op = '{off: IER_DLM, dat: div[15:8]};
      3'd3:    op = '{off: LCR,     dat: lcr};
      default: op = '{off: FCR,     dat: FCR_INIT};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/uart_sched_rr_arbiter.sv
// Round-robin winner select: first valid requester at or after the pointer.
// Latency: combinational.
// Backpressure: none; the caller decides when the winner is taken.
module uart_sched_rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NR_REQ = 4,
  localparam int PTR_W = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0] req_valid_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [PTR_W-1:0]  winner_o,
  output logic              any_valid_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Rotate the scan start to the pointer and keep the first hit.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NR_REQ)) sum = sum - (PTR_W+1)'(NR_REQ);
      idx = sum[PTR_W-1:0];
      if (!any_valid_o && req_valid_i[idx]) begin
        winner_o    = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Bus master that configures a 16550 UART, then polls LSR and feeds THR from NR_REQ requesters.
// Latency: 5 cycles per write with immediate grant; reads last until the slave ends them.
// Backpressure: requestBus held until busGrant; reqReady pulses only when a byte's write completes.
// Optional UART_SCHED_TIMEOUT_EN: read watchdog that aborts after TIMEOUT_CYCLES wait cycles.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int          NR_REQ         = 4,
  parameter logic [31:0] UART_BASE      = 32'h5000_0000,
  parameter logic [15:0] BAUD_DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VALUE      = 8'h03,
  parameter int          TX_BURST       = 16,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NR_REQ-1:0]     reqValid,
  input  logic [8*NR_REQ-1:0]   reqData,
  output logic [NR_REQ-1:0]     reqReady,
  output logic                  requestBus,
  input  logic                  busGrant,
  output logic                  beginTransactionOut,
  output logic                  readNWriteOut,
  output logic [31:0]           addressDataOut,
  output logic [3:0]            byteEnablesOut,
  output logic [7:0]            burstSizeOut,
  output logic                  dataValidOut,
  output logic                  endTransactionOut,
  output logic                  busyOut,
  input  logic [31:0]           addressDataIn,
  input  logic                  dataValidIn,
  input  logic                  endTransactionIn,
  input  logic                  busErrorIn,
  output logic                  initDone,
  output logic                  errorSticky
);

  localparam int PTR_W = $clog2(NR_REQ);

  state_t           state_q, state_d;
  logic [2:0]       init_idx_q;
  logic [PTR_W-1:0] ptr_q, win_q, win, ptr_nxt;
  logic [4:0]       burst_q;
  logic [2:0]       op_off_q;
  logic [7:0]       op_dat_q;
  logic             op_rd_q, op_byte_q, err_q;
  logic             any_vld, init_done, bus_active, abort, sel, tmo_hit;
  init_op_t         init_sel;

`ifdef UART_SCHED_TIMEOUT_EN
  logic [9:0] tmo_q;
  assign tmo_hit = (state_q == ST_RWAIT || state_q == ST_REND) && (tmo_q == 10'(TIMEOUT_CYCLES));

  // Watchdog: cleared on each address phase, counts while waiting on the read slave.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                             tmo_q <= '0;
    else if (state_q == ST_BEGIN)                           tmo_q <= '0;
    else if ((state_q == ST_RWAIT || state_q == ST_REND) && !tmo_hit) tmo_q <= tmo_q + 10'd1;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  uart_sched_rr_arbiter #(.NR_REQ(NR_REQ)) u_arb (
    .req_valid_i (reqValid),
    .ptr_i       (ptr_q),
    .winner_o    (win),
    .any_valid_o (any_vld)
  );

  logic unused_rd;
  assign unused_rd  = ^(addressDataIn & ~(32'h1 << (8 + LSR_THRE_BIT)));

  assign init_done  = (init_idx_q == INIT_OPS);
  assign init_sel   = init_op(init_idx_q, {1'b0, LCR_VALUE[6:0]}, BAUD_DIVISOR);
  assign bus_active = (state_q == ST_BEGIN) || (state_q == ST_WDATA) || (state_q == ST_WEND) ||
                      (state_q == ST_RWAIT) || (state_q == ST_REND);
  assign abort      = bus_active && (busErrorIn || tmo_hit);
  assign sel        = (state_q == ST_INIT) && (!init_done || any_vld);
  assign ptr_nxt    = (win_q == PTR_W'(NR_REQ - 1)) ? '0 : win_q + PTR_W'(1);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next-state: walk one bus transaction; any error or timeout drops straight back to select.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (sel) state_d = ST_REQ;
      ST_REQ:   if (busGrant) state_d = ST_BEGIN;
      ST_BEGIN: state_d = op_rd_q ? ST_RWAIT : ST_WDATA;
      ST_WDATA: state_d = ST_WEND;
      ST_WEND:  state_d = ST_INIT;
      ST_RWAIT: if (dataValidIn) state_d = endTransactionIn ? ST_INIT : ST_REND;
      ST_REND:  if (endTransactionIn) state_d = ST_INIT;
      default:  state_d = ST_INIT;
    endcase
    if (abort) state_d = ST_INIT;
  end

  // Datapath: latch the chosen op at select time, track init progress, burst budget and pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      init_idx_q <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
      burst_q    <= '0;
      op_off_q   <= '0;
      op_dat_q   <= '0;
      op_rd_q    <= 1'b0;
      op_byte_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (sel) begin
        if (!init_done) begin
          op_off_q  <= init_sel.off;
          op_dat_q  <= init_sel.dat;
          op_rd_q   <= 1'b0;
          op_byte_q <= 1'b0;
        end else if (burst_q != 5'd0) begin
          op_off_q  <= RBR_THR;
          op_dat_q  <= reqData[{win, 3'b000} +: 8];
          win_q     <= win;
          op_rd_q   <= 1'b0;
          op_byte_q <= 1'b1;
        end else begin
          op_off_q  <= LSR;
          op_dat_q  <= '0;
          op_rd_q   <= 1'b1;
          op_byte_q <= 1'b0;
        end
      end
      // Nobody pending at select time ends the burst; the next byte waits for a fresh poll.
      if (state_q == ST_INIT && init_done && !any_vld) burst_q <= '0;
      if (state_q == ST_WEND && op_byte_q) begin
        ptr_q   <= ptr_nxt;
        burst_q <= burst_q - 5'd1;
      end
      if (state_q == ST_RWAIT && dataValidIn)
        burst_q <= addressDataIn[8 + LSR_THRE_BIT] ? 5'(TX_BURST) : 5'd0;
      if ((state_q == ST_WEND || abort) && !init_done) init_idx_q <= init_idx_q + 3'd1;
      if (abort) begin
        err_q   <= 1'b1;
        burst_q <= '0;
      end
    end
  end

  // Bus outputs decoded from registered state only, so reset clears them immediately.
  always_comb begin
    requestBus          = (state_q != ST_INIT);
    beginTransactionOut = (state_q == ST_BEGIN);
    readNWriteOut       = (state_q == ST_BEGIN) && op_rd_q;
    dataValidOut        = (state_q == ST_WDATA);
    endTransactionOut   = (state_q == ST_WEND) || tmo_hit;
    byteEnablesOut      = '0;
    addressDataOut      = '0;
    reqReady            = '0;
    if (state_q == ST_BEGIN) begin
      byteEnablesOut = 4'b0001 << op_off_q[1:0];
      addressDataOut = UART_BASE + {29'd0, op_off_q};
    end
    if (state_q == ST_WDATA) addressDataOut = {24'd0, op_dat_q} << {op_off_q[1:0], 3'b000};
    if (state_q == ST_WEND && op_byte_q) reqReady[win_q] = 1'b1;
  end

  assign burstSizeOut = '0;
  assign busyOut      = 1'b0;
  assign initDone     = init_done;
  assign errorSticky  = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected bus transactions are queued by the stimulus,
// a monitor assembles each DUT transaction and compares it, a slave model answers LSR reads.
module tb_uart_tx_scheduler;
  localparam int NR_REQ = 4;
  localparam logic [31:0] BASE = 32'h5000_0000;

  logic                clock = 1'b0;
  logic                reset;
  logic [NR_REQ-1:0]   reqValid, reqReady;
  logic [8*NR_REQ-1:0] reqData;
  logic                requestBus, busGrant, beginTransactionOut, readNWriteOut;
  logic [31:0]         addressDataOut, addressDataIn;
  logic [3:0]          byteEnablesOut;
  logic [7:0]          burstSizeOut;
  logic                dataValidOut, endTransactionOut, busyOut;
  logic                dataValidIn, endTransactionIn, busErrorIn, initDone, errorSticky;

  always #5 clock = ~clock;

  uart_tx_scheduler dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
    .requestBus(requestBus), .busGrant(busGrant), .beginTransactionOut(beginTransactionOut),
    .readNWriteOut(readNWriteOut), .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut), .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
    .busyOut(busyOut), .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn), .initDone(initDone),
    .errorSticky(errorSticky)
  );

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [3:0]  rdy;
  } txn_t;

  txn_t     exp_q[$];
  logic [7:0] lsr_q[$];
  int       n_chk = 0, n_pass = 0, n_txn = 0;
  bit       silent = 1'b0;
  int       err_at = 0, a2_seen = 0;
  int       rdy_cnt[NR_REQ];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic push_wr(input logic [2:0] off, input logic [7:0] dat, input logic [3:0] rdy);
    txn_t t;
    t.rd   = 1'b0;
    t.addr = BASE + {29'd0, off};
    t.be   = 4'b0001 << off[1:0];
    t.data = {24'd0, dat} << {off[1:0], 3'b000};
    t.rdy  = rdy;
    exp_q.push_back(t);
  endtask

  task automatic push_rd();
    txn_t t;
    t = '{rd: 1'b1, addr: BASE + 32'd5, be: 4'b0010, data: 32'd0, rdy: 4'd0};
    exp_q.push_back(t);
  endtask

  task automatic push_byte(input int n);
    push_wr(3'd0, 8'hA0 + 8'(n), 4'b0001 << n);
  endtask

  task automatic score(input txn_t got);
    txn_t want;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL txn_unexpected: got %0h, required none", got);
    end else begin
      want = exp_q.pop_front();
      check($sformatf("txn%0d", n_txn), 80'(got), 80'(want));
    end
    n_txn++;
  endtask

  // Monitor: assemble each transaction; reads are scored at the address phase, writes at the end strobe.
  initial begin : monitor
    txn_t cur;
    cur = '0;
    for (int n = 0; n < NR_REQ; n++) rdy_cnt[n] = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (beginTransactionOut) begin
          cur = '{rd: readNWriteOut, addr: addressDataOut, be: byteEnablesOut, data: 32'd0, rdy: 4'd0};
          if (readNWriteOut) score(cur);
        end
        if (dataValidOut) cur.data = addressDataOut;
        if (endTransactionOut && !cur.rd) begin
          cur.rdy = reqReady;
          score(cur);
        end
        for (int n = 0; n < NR_REQ; n++) if (reqReady[n]) rdy_cnt[n]++;
      end
    end
  end

  // Slave model: answer each read one cycle after its address phase; inject the armed bus error.
  initial begin : slave
    bit rd_pend;
    logic [7:0] lsr;
    rd_pend = 1'b0;
    dataValidIn = 1'b0; endTransactionIn = 1'b0; busErrorIn = 1'b0; addressDataIn = '0;
    forever begin
      @(negedge clock);
      dataValidIn = 1'b0; endTransactionIn = 1'b0; busErrorIn = 1'b0; addressDataIn = '0;
      if (rd_pend) begin
        if (lsr_q.size() != 0) lsr = lsr_q.pop_front();
        else lsr = 8'h00;
        dataValidIn = 1'b1; endTransactionIn = 1'b1;
        addressDataIn = {16'd0, lsr, 8'd0};
        rd_pend = 1'b0;
      end
      if (reset && beginTransactionOut && readNWriteOut && !silent) rd_pend = 1'b1;
      if (reset && dataValidOut && addressDataOut[7:0] == 8'hA2) begin
        a2_seen++;
        if (a2_seen == err_at) busErrorIn = 1'b1;
      end
    end
  end

  initial begin : stim
    int busy, cyc;
    reset = 1'b0; busGrant = 1'b1; reqValid = '0;
    reqData = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (3) @(negedge clock);
    check("reset_outputs",
          80'({reqReady, requestBus, beginTransactionOut, readNWriteOut, addressDataOut, byteEnablesOut,
               burstSizeOut, dataValidOut, endTransactionOut, busyOut, initDone, errorSticky}), 80'd0);

    // Configuration writes: LCR|DLAB, DLL, DLM, LCR, FCR.
    push_wr(3'd3, 8'h83, 4'd0);
    push_wr(3'd0, 8'h1B, 4'd0);
    push_wr(3'd1, 8'h00, 4'd0);
    push_wr(3'd3, 8'h03, 4'd0);
    push_wr(3'd2, 8'h07, 4'd0);
    reset = 1'b1;
    for (int i = 0; i < 200 && !initDone; i++) @(negedge clock);
    check("initDone", 80'(initDone), 80'd1);
    check("init_error", 80'(errorSticky), 80'd0);
    check("init_txns_left", 80'(exp_q.size()), 80'd0);

    busy = 0;
    repeat (100) begin
      @(negedge clock);
      if (requestBus) busy++;
    end
    check("idle_requestBus_cycles", 80'(busy), 80'd0);

    // Burst of 16 round-robin bytes, three not-ready polls, then two bytes and an aborted third.
    push_rd();
    for (int i = 0; i < 16; i++) push_byte(i % 4);
    repeat (4) push_rd();
    push_byte(0);
    push_byte(1);
    push_rd();
    lsr_q = '{8'h60, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
    err_at = 5;
    reqValid = 4'hF;
    for (int i = 0; i < 2000 && !errorSticky; i++) @(negedge clock);
    check("errorSticky_set", 80'(errorSticky), 80'd1);
    for (int i = 0; i < 50 && !(beginTransactionOut && readNWriteOut); i++) @(negedge clock);
    check("repoll_after_error", 80'(beginTransactionOut && readNWriteOut), 80'd1);
    reqValid = '0;
    repeat (50) @(negedge clock);
    check("txns_left", 80'(exp_q.size()), 80'd0);
    check("lsr_left", 80'(lsr_q.size()), 80'd0);
    check("rdy_cnt0", 80'(rdy_cnt[0]), 80'd5);
    check("rdy_cnt1", 80'(rdy_cnt[1]), 80'd5);
    check("rdy_cnt2", 80'(rdy_cnt[2]), 80'd4);
    check("rdy_cnt3", 80'(rdy_cnt[3]), 80'd4);
    check("idle_after_drop", 80'(requestBus), 80'd0);

`ifdef UART_SCHED_TIMEOUT_EN
    // Silent slave: the read is abandoned with an end strobe 1024 cycles after its address phase.
    silent = 1'b1;
    push_rd();
    reqValid = 4'h1;
    for (int i = 0; i < 50 && !(beginTransactionOut && readNWriteOut); i++) @(negedge clock);
    check("tmo_read_begin", 80'(beginTransactionOut && readNWriteOut), 80'd1);
    cyc = 0;
    while (cyc < 1100 && !endTransactionOut) begin
      @(negedge clock);
      cyc++;
    end
    check("tmo_cycles", 80'(cyc), 80'd1024);
    silent = 1'b0;
    push_rd();
    @(negedge clock);
    for (int i = 0; i < 50 && !(beginTransactionOut && readNWriteOut); i++) @(negedge clock);
    check("tmo_repoll", 80'(beginTransactionOut && readNWriteOut), 80'd1);
    reqValid = '0;
    repeat (20) @(negedge clock);
    check("tmo_txns_left", 80'(exp_q.size()), 80'd0);
    check("tmo_error", 80'(errorSticky), 80'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
